// File: rtl/alu_issue_ctrl_if.sv
//============================================================================
// Module      : alu_issue_ctrl_if
// Description : Instruction fetch handshake between an instruction source
//               (master) and the ALU issue controller (slave).
//                 instr        8  {op[7:5], rsvd[4], rd[3:2], rs[1:0]}
//                 instr_valid  1  instr is valid (source side)
//                 instr_ready  1  controller accepts instr this cycle
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface alu_issue_ctrl_if;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
//============================================================================
// Module      : alu_issue_ctrl
// Description : Control end of an 8-bit ALU datapath. Fetches one
//               instruction at a time, decodes it into ALU operands and
//               select lines, and writes the ALU result back into a 4x8
//               register file. Also owns the carry flag.
//               Sequence: FETCH -> DECODE -> EXEC, one instruction in
//               flight, 1 instruction per 3 cycles.
// Ports       : clk, rst            clock / synchronous active-high reset
//               instr_if (slave)    instruction valid/ready handshake
//               ld_en/addr/data     direct register load (FETCH only)
//               alu_a, alu_b        operands R[rd], R[rs] (registered)
//               alu_sel[4:0]        {s4,s3,s2,s1,s0} to the ALU
//               alu_o, alu_cout     ALU result and carry out
//               carry               carry flag
//               done                one-cycle pulse on writeback (EXEC)
//               dbg_addr/dbg_data   combinational register read port
//               zero                zero flag (ALU_CTRL_ZFLAG_EN only)
// Options     : ALU_CTRL_ZFLAG_EN - adds the zero flag output.
// Notes       : DATA_W must be 8 and REG_AW must be 2; the instruction
//               format hard-codes 2-bit register fields.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   instr_if,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_cout,
    output logic              carry,
    output logic              done,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`ifdef ALU_CTRL_ZFLAG_EN
    ,
    output logic              zero
`endif
);

    localparam int C_NREGS = 1 << REG_AW;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_MOV  = 3'b011;
    localparam logic [2:0] C_OP_INC  = 3'b100;
    localparam logic [2:0] C_OP_NOP  = 3'b101;
    localparam logic [2:0] C_OP_ADC  = 3'b110;
    localparam logic [2:0] C_OP_CLRC = 3'b111;

    localparam logic [4:0] C_SEL_ADD = 5'b00000;
    localparam logic [4:0] C_SEL_SUB = 5'b01100;
    localparam logic [4:0] C_SEL_AND = 5'b00001;
    localparam logic [4:0] C_SEL_MOV = 5'b00011;
    localparam logic [4:0] C_SEL_INC = 5'b10100;
    localparam logic [4:0] C_SEL_NOP = 5'b00010;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DATA_W-1:0]  r_regs [C_NREGS];
    logic [2:0]         r_op;
    logic [REG_AW-1:0]  r_rd;
    logic [REG_AW-1:0]  r_rs;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [4:0]         r_alu_sel;
    logic               r_carry;
`ifdef ALU_CTRL_ZFLAG_EN
    logic               r_zero;
`endif

    logic               w_instr_ready;
    logic               w_done;
    logic               w_ld_fire;
    logic               w_accept;
    logic [4:0]         w_sel_dec;
    logic               w_wr_rd;
    logic               w_wr_carry;

    // Reserved instruction bit is deliberately ignored.
    logic               w_unused_rsvd;
    assign w_unused_rsvd = instr_if.instr[4];

    //------------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // FSM next state and handshake/strobe outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_done        = 1'b0;
        w_ld_fire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // A direct load wins over instruction fetch in the same cycle.
                w_ld_fire     = ld_en;
                w_instr_ready = ~ld_en;
                if (instr_if.instr_valid && !ld_en) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_done      = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
        // Reset held mid-instruction must suppress ready and the done pulse
        // in the same cycle, not one cycle later.
        if (rst) begin
            w_instr_ready = 1'b0;
            w_done        = 1'b0;
            w_ld_fire     = 1'b0;
        end
    end

    assign w_accept = instr_if.instr_valid && w_instr_ready;

    //------------------------------------------------------------------------
    // Opcode decode: ALU select lines and writeback enables
    //------------------------------------------------------------------------
    always_comb begin
        w_sel_dec  = C_SEL_NOP;
        w_wr_rd    = 1'b0;
        w_wr_carry = 1'b0;
        case (r_op)
            C_OP_ADD: begin
                w_sel_dec  = C_SEL_ADD;
                w_wr_rd    = 1'b1;
                w_wr_carry = 1'b1;
            end
            C_OP_SUB: begin
                w_sel_dec  = C_SEL_SUB;
                w_wr_rd    = 1'b1;
                w_wr_carry = 1'b1;
            end
            C_OP_AND: begin
                w_sel_dec = C_SEL_AND;
                w_wr_rd   = 1'b1;
            end
            C_OP_MOV: begin
                w_sel_dec = C_SEL_MOV;
                w_wr_rd   = 1'b1;
            end
            C_OP_INC: begin
                w_sel_dec  = C_SEL_INC;
                w_wr_rd    = 1'b1;
                w_wr_carry = 1'b1;
            end
            C_OP_ADC: begin
                // Carry-in line s2 carries the flag as it stands at DECODE.
                w_sel_dec  = {2'b00, r_carry, 2'b00};
                w_wr_rd    = 1'b1;
                w_wr_carry = 1'b1;
            end
            default: begin
                // NOP and CLRC drive the idle select and write no register.
                w_sel_dec = C_SEL_NOP;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath: register file, instruction register, operands, flags
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_op      <= C_OP_NOP;
            r_rd      <= '0;
            r_rs      <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= C_SEL_NOP;
            r_carry   <= 1'b0;
`ifdef ALU_CTRL_ZFLAG_EN
            r_zero    <= 1'b0;
`endif
        end else begin
            if (w_ld_fire) begin
                r_regs[ld_addr] <= ld_data;
            end

            if (w_accept) begin
                r_op <= instr_if.instr[7:5];
                r_rd <= instr_if.instr[3:2];
                r_rs <= instr_if.instr[1:0];
            end

            if (r_state == ST_DECODE) begin
                r_alu_a   <= r_regs[r_rd];
                r_alu_b   <= r_regs[r_rs];
                r_alu_sel <= w_sel_dec;
            end

            if (r_state == ST_EXEC) begin
                if (w_wr_rd) begin
                    r_regs[r_rd] <= alu_o;
                end
                if (w_wr_carry) begin
                    r_carry <= alu_cout;
                end else if (r_op == C_OP_CLRC) begin
                    r_carry <= 1'b0;
                end
`ifdef ALU_CTRL_ZFLAG_EN
                if (w_wr_rd) begin
                    r_zero <= (alu_o == '0);
                end
`endif
            end
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign instr_if.instr_ready = w_instr_ready;
    assign done                 = w_done;
    assign alu_a                = r_alu_a;
    assign alu_b                = r_alu_b;
    assign alu_sel              = r_alu_sel;
    assign carry                = r_carry;
    assign dbg_data             = r_regs[dbg_addr];
`ifdef ALU_CTRL_ZFLAG_EN
    assign zero                 = r_zero;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
//============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. Provides a
//               behavioural ALU driven by alu_sel, a register/carry model,
//               and a scoreboard of expected writebacks.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_AND  = 3'b010;
    localparam logic [2:0] C_OP_MOV  = 3'b011;
    localparam logic [2:0] C_OP_INC  = 3'b100;
    localparam logic [2:0] C_OP_NOP  = 3'b101;
    localparam logic [2:0] C_OP_ADC  = 3'b110;
    localparam logic [2:0] C_OP_CLRC = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] alu_sel;
    logic [7:0] alu_o;
    logic       alu_cout;
    logic       carry;
    logic       done;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
`ifdef ALU_CTRL_ZFLAG_EN
    logic       zero;
`endif

    alu_issue_ctrl_if ibus ();

    alu_issue_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .instr_if (ibus),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_o    (alu_o),
        .alu_cout (alu_cout),
        .carry    (carry),
        .done     (done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`ifdef ALU_CTRL_ZFLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU: s1s0 = 00 arith, 01 and, 11 pass b;
    // s4 zeroes b, s3 inverts b, s2 is carry-in.
    logic [7:0] w_bb;
    logic [8:0] w_sum;
    always_comb begin
        w_bb     = alu_sel[4] ? 8'h00 : (alu_sel[3] ? ~alu_b : alu_b);
        w_sum    = {1'b0, alu_a} + {1'b0, w_bb} + {8'h00, alu_sel[2]};
        alu_o    = 8'h00;
        alu_cout = 1'b0;
        case (alu_sel[1:0])
            2'b00: begin
                alu_o    = w_sum[7:0];
                alu_cout = w_sum[8];
            end
            2'b01:   alu_o = alu_a & alu_b;
            2'b11:   alu_o = alu_b;
            default: alu_o = 8'h00;
        endcase
    end

    typedef struct packed {
        logic [4:0] sel;
        logic [1:0] rd;
        logic [7:0] val;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] m_regs [4];
    logic       m_carry;
    logic       m_zero;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_carry = 1'b0;
        m_zero  = 1'b0;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        m_regs[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_reg(input logic [1:0] a);
        dbg_addr = a;
        #1;
        check("reg", dbg_data, m_regs[a]);
    endtask

    // Drives one instruction, waits for its acceptance, and (if push) queues
    // the expected writeback. Returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs, input bit push);
        exp_t       e;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] r;
        bit         acc;
        int         waits;
        a     = m_regs[rd];
        b     = m_regs[rs];
        e.rd  = rd;
        e.val = a;
        e.c   = m_carry;
        e.z   = m_zero;
        e.sel = 5'b00010;
        case (op)
            C_OP_ADD: begin
                r = {1'b0, a} + {1'b0, b};
                e.sel = 5'b00000; e.val = r[7:0]; e.c = r[8];
            end
            C_OP_SUB: begin
                e.sel = 5'b01100; e.val = a - b; e.c = (a >= b);
            end
            C_OP_AND: begin
                e.sel = 5'b00001; e.val = a & b;
            end
            C_OP_MOV: begin
                e.sel = 5'b00011; e.val = b;
            end
            C_OP_INC: begin
                r = {1'b0, a} + 9'd1;
                e.sel = 5'b10100; e.val = r[7:0]; e.c = r[8];
            end
            C_OP_ADC: begin
                r = {1'b0, a} + {1'b0, b} + {8'h00, m_carry};
                e.sel = {2'b00, m_carry, 2'b00}; e.val = r[7:0]; e.c = r[8];
            end
            C_OP_CLRC: e.c = 1'b0;
            default:   e.c = m_carry;
        endcase
        if (op != C_OP_NOP && op != C_OP_CLRC) e.z = (e.val == 8'h00);

        @(negedge clk);
        ld_en             = 1'b0;
        dbg_addr          = rd;
        ibus.instr        = {op, 1'b1, rd, rs};
        ibus.instr_valid  = 1'b1;
        acc   = 1'b0;
        waits = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (ibus.instr_ready) begin
                acc = 1'b1;
                break;
            end
            waits++;
            @(negedge clk);
        end
        if (!acc) begin
            check("accept_timeout", 0, 1);
            ibus.instr_valid = 1'b0;
            return;
        end
        check("accept_wait", waits, 0);
        if (push) begin
            m_regs[rd] = e.val;
            m_carry    = e.c;
            m_zero     = e.z;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        ibus.instr_valid = 1'b0;
    endtask

    // Waits for done, pops the scoreboard and compares select, writeback
    // value, flags and pulse width. With stray set, a load to stray_addr is
    // requested while the instruction is busy; it must be ignored.
    task automatic wait_wb(input bit stray, input logic [1:0] stray_addr);
        exp_t e;
        int   n;
        bit   seen;
        seen = 1'b0;
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stray) begin
                ld_en   = 1'b1;
                ld_addr = stray_addr;
                ld_data = 8'h5A;
            end
        end
        if (!seen) begin
            check("done_timeout", 0, 1);
            ld_en = 1'b0;
            return;
        end
        // done marks the cycle whose closing edge performs the write.
        check("latency", n + 1, 3);
        if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check("alu_sel", alu_sel, e.sel);
        @(negedge clk);
        ld_en = 1'b0;
        check("done_pulse", done, 0);
        check("wb_value", dbg_data, e.val);
        check("carry", carry, e.c);
`ifdef ALU_CTRL_ZFLAG_EN
        check("zero", zero, e.z);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_done;
        rst              = 1'b1;
        ld_en            = 1'b0;
        ld_addr          = 2'd0;
        ld_data          = 8'h00;
        dbg_addr         = 2'd0;
        ibus.instr       = 8'h00;
        ibus.instr_valid = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", ibus.instr_ready, 0);
        check("rst_done", done, 0);
        check("rst_sel", alu_sel, 5'b00010);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_carry", carry, 0);
`ifdef ALU_CTRL_ZFLAG_EN
        check("rst_zero", zero, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 4; i++) check_reg(i[1:0]);

        // ADD 05+03
        load(2'd0, 8'h05); load(2'd1, 8'h03);
        issue(C_OP_ADD, 2'd0, 2'd1, 1'b1); wait_wb(1'b0, 2'd0);

        // SUB with and without borrow
        load(2'd0, 8'h03); load(2'd1, 8'h05);
        issue(C_OP_SUB, 2'd0, 2'd1, 1'b1); wait_wb(1'b0, 2'd0);
        load(2'd2, 8'h07); load(2'd3, 8'h02);
        issue(C_OP_SUB, 2'd2, 2'd3, 1'b1); wait_wb(1'b0, 2'd0);

        // Wrap to zero, then ADC consuming the carry
        load(2'd0, 8'hFF); load(2'd1, 8'h01);
        issue(C_OP_ADD, 2'd0, 2'd1, 1'b1); wait_wb(1'b0, 2'd0);
        load(2'd2, 8'h10); load(2'd3, 8'h20);
        issue(C_OP_ADC, 2'd2, 2'd3, 1'b1); wait_wb(1'b0, 2'd0);

        // Load has priority over a pending instruction in FETCH
        @(negedge clk);
        dbg_addr         = 2'd3;
        ld_en            = 1'b1;
        ld_addr          = 2'd3;
        ld_data          = 8'hA5;
        m_regs[3]        = 8'hA5;
        ibus.instr       = {C_OP_MOV, 1'b0, 2'd2, 2'd3};
        ibus.instr_valid = 1'b1;
        #1;
        check("ld_prio_ready", ibus.instr_ready, 0);
        issue(C_OP_MOV, 2'd2, 2'd3, 1'b1); wait_wb(1'b0, 2'd0);
        check_reg(2'd3);

        // AND with a load request arriving while busy (ignored)
        load(2'd0, 8'h3C);
        issue(C_OP_AND, 2'd2, 2'd0, 1'b1); wait_wb(1'b1, 2'd1);
        check_reg(2'd1);

        // rd == rs, and INC
        issue(C_OP_ADD, 2'd1, 2'd1, 1'b1); wait_wb(1'b0, 2'd0);
        issue(C_OP_INC, 2'd3, 2'd3, 1'b1); wait_wb(1'b0, 2'd0);

        // Reset during EXEC of INC R1 with R1=FF and carry=1
        load(2'd0, 8'h80);
        issue(C_OP_ADD, 2'd0, 2'd0, 1'b1); wait_wb(1'b0, 2'd0);
        load(2'd1, 8'hFF);
        issue(C_OP_INC, 2'd1, 2'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_done", done, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_fetch_ready", ibus.instr_ready, 1);
        check("rst_mid_carry", carry, 0);
        check_reg(2'd1);
        any_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_done = any_done | done;
        end
        check("rst_no_done", any_done, 0);

        // CLRC after carry=1, then NOP: no register change
        load(2'd0, 8'hFF); load(2'd1, 8'h01);
        issue(C_OP_ADD, 2'd0, 2'd1, 1'b1); wait_wb(1'b0, 2'd0);
        load(2'd2, 8'h77); load(2'd3, 8'h88);
        issue(C_OP_CLRC, 2'd2, 2'd3, 1'b1); wait_wb(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) check_reg(i[1:0]);
        issue(C_OP_NOP, 2'd3, 2'd2, 1'b1); wait_wb(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) check_reg(i[1:0]);

        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
